// File: rtl/stall_credit_ctrl.sv
// stall_credit_ctrl: credit-based dispatch hazard controller with registered throttling and flush recovery; STALL_CREDIT_PERF_EN adds per-cause stall counters
module stall_credit_ctrl #(
    parameter int NUM_CH = 5,
    parameter int CNT_W = 5,
    parameter logic [NUM_CH*CNT_W-1:0] CH_DEPTH = {5'd8, 5'd4, 5'd4, 5'd8, 5'd8},
    parameter int ROB_SIZE = 16,
    parameter int LSQ_SIZE = 16,
    parameter int WATERMARK = 1,
    parameter int FLUSH_CYCLES = 3,
    localparam int CH_W = $clog2(NUM_CH),
    localparam int ROB_W = $clog2(ROB_SIZE + 1),
    localparam int LSQ_W = $clog2(LSQ_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic [CH_W-1:0]          disp_ch,
    input  logic                     disp_is_mem,
    output logic                     disp_ready,
    input  logic [NUM_CH-1:0]        rs_release,
    input  logic                     rob_commit,
    input  logic                     lsq_release,
    output logic [NUM_CH*CNT_W-1:0]  ch_credit,
    output logic                     stall_dispatch,
    output logic                     stall_decode,
    output logic                     stall_fetch,
    output logic [NUM_CH+1:0]        stall_cause,
    output logic                     credit_err,
    output logic [(NUM_CH+2)*16-1:0] perf_stall_cnt
);
    typedef enum logic {RUN, RECOVER} state_t;
    state_t state, state_nxt;
    logic [1:0] rcnt, rcnt_nxt;
    logic [CNT_W-1:0] credit [NUM_CH];
    logic [CNT_W-1:0] credit_nxt [NUM_CH];
    logic [ROB_W-1:0] rob_free, rob_nxt;
    logic [LSQ_W-1:0] lsq_free, lsq_nxt;
    logic [NUM_CH-1:0] take_ch, give_ch, full_ch;
    logic [NUM_CH+1:0] cause_nxt;
    logic sel_empty, fire, live, err_nxt;
    logic rob_give, rob_full, lsq_take, lsq_give, lsq_full;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign take_ch[i] = fire && disp_ch == CH_W'(i);
        assign give_ch[i] = live && rs_release[i];
        assign full_ch[i] = credit[i] == CH_DEPTH[i*CNT_W +: CNT_W];
        assign ch_credit[i*CNT_W +: CNT_W] = credit[i];
    end

    assign rob_give = live && rob_commit;
    assign rob_full = rob_free == ROB_W'(ROB_SIZE);
    assign lsq_take = fire && disp_is_mem;
    assign lsq_give = live && lsq_release;
    assign lsq_full = lsq_free == LSQ_W'(LSQ_SIZE);

    // Accept a request only in RUN with room in the target channel, the ROB and (if needed) the LSQ
    always_comb begin
        sel_empty = 1'b1;
        for (int k = 0; k < NUM_CH; k++)
            if (disp_ch == CH_W'(k)) sel_empty = credit[k] == '0;
        disp_ready = state == RUN && !flush && !sel_empty && rob_free != '0 && (!disp_is_mem || lsq_free != '0);
        fire = disp_valid && disp_ready;
        stall_dispatch = disp_valid && !disp_ready;
        live = state == RUN && !flush;
    end

    // Next free counts: reload on flush, else net of dispatch and release, holding at the top on a spurious release
    always_comb begin
        err_nxt = credit_err;
        cause_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            credit_nxt[k] = flush ? CH_DEPTH[k*CNT_W +: CNT_W]
                          : take_ch[k] && !give_ch[k] ? credit[k] - CNT_W'(1)
                          : give_ch[k] && !take_ch[k] && !full_ch[k] ? credit[k] + CNT_W'(1) : credit[k];
            err_nxt = err_nxt | (give_ch[k] && !take_ch[k] && full_ch[k]);
            cause_nxt[k] = credit_nxt[k] <= CNT_W'(WATERMARK);
        end
        rob_nxt = flush ? ROB_W'(ROB_SIZE)
                : fire && !rob_give ? rob_free - ROB_W'(1)
                : rob_give && !fire && !rob_full ? rob_free + ROB_W'(1) : rob_free;
        lsq_nxt = flush ? LSQ_W'(LSQ_SIZE)
                : lsq_take && !lsq_give ? lsq_free - LSQ_W'(1)
                : lsq_give && !lsq_take && !lsq_full ? lsq_free + LSQ_W'(1) : lsq_free;
        err_nxt = err_nxt | (rob_give && !fire && rob_full) | (lsq_give && !lsq_take && lsq_full);
        cause_nxt[NUM_CH] = rob_nxt <= ROB_W'(WATERMARK);
        cause_nxt[NUM_CH+1] = lsq_nxt <= LSQ_W'(WATERMARK);
    end

    // Recovery sequencer: flush (re)arms the countdown, reaching zero returns to RUN
    always_comb begin
        state_nxt = state;
        rcnt_nxt = rcnt;
        if (flush) begin
            state_nxt = RECOVER;
            rcnt_nxt = 2'(FLUSH_CYCLES - 1);
        end else if (state == RECOVER) begin
            state_nxt = rcnt == 2'd0 ? RUN : RECOVER;
            rcnt_nxt = rcnt == 2'd0 ? rcnt : rcnt - 2'd1;
        end
    end

    // Counters, FSM and the registered throttle pipeline (decode then fetch)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rcnt <= '0;
            rob_free <= ROB_W'(ROB_SIZE);
            lsq_free <= LSQ_W'(LSQ_SIZE);
            for (int k = 0; k < NUM_CH; k++) credit[k] <= CH_DEPTH[k*CNT_W +: CNT_W];
            stall_cause <= '0;
            stall_decode <= 1'b0;
            stall_fetch <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt <= rcnt_nxt;
            rob_free <= rob_nxt;
            lsq_free <= lsq_nxt;
            for (int k = 0; k < NUM_CH; k++) credit[k] <= credit_nxt[k];
            stall_cause <= cause_nxt;
            stall_decode <= |cause_nxt || state_nxt == RECOVER;
            stall_fetch <= stall_decode;
            credit_err <= err_nxt;
        end
    end

`ifdef STALL_CREDIT_PERF_EN
    logic [NUM_CH+1:0] blk;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_blk
        assign blk[i] = disp_ch == CH_W'(i) && credit[i] == '0;
    end
    assign blk[NUM_CH] = rob_free == '0;
    assign blk[NUM_CH+1] = disp_is_mem && lsq_free == '0;
    for (genvar i = 0; i < NUM_CH + 2; i++) begin : g_perf
        logic [15:0] cnt;
        // Saturating count of cycles this cause blocked a dispatch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (stall_dispatch && blk[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
        assign perf_stall_cnt[i*16 +: 16] = cnt;
    end
`else
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_stall_credit_ctrl.sv
// tb_stall_credit_ctrl: directed stimulus against a counts-based reference model of the dispatch credit controller
module tb_stall_credit_ctrl;
    localparam int NUM_CH = 5;
    localparam int CNT_W = 5;
    localparam int WM = 1;
    localparam int ROB_SIZE = 16;
    localparam int LSQ_SIZE = 16;
    localparam int FLUSH_CYCLES = 3;
    localparam int DEPTH [NUM_CH] = '{8, 8, 4, 4, 8};

    logic clk, rst_n, flush, disp_valid, disp_is_mem, rob_commit, lsq_release;
    logic [2:0] disp_ch;
    logic [NUM_CH-1:0] rs_release;
    logic disp_ready, stall_dispatch, stall_decode, stall_fetch, credit_err;
    logic [NUM_CH*CNT_W-1:0] ch_credit;
    logic [NUM_CH+1:0] stall_cause;
    logic [(NUM_CH+2)*16-1:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    int m_cr [NUM_CH];
    int m_rob, m_lsq, m_rec;
    int m_perf [NUM_CH+2];
    bit m_dec, m_fetch, m_err;
    bit [NUM_CH+1:0] m_cause;

    stall_credit_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid), .disp_ch(disp_ch),
        .disp_is_mem(disp_is_mem), .disp_ready(disp_ready), .rs_release(rs_release),
        .rob_commit(rob_commit), .lsq_release(lsq_release), .ch_credit(ch_credit),
        .stall_dispatch(stall_dispatch), .stall_decode(stall_decode), .stall_fetch(stall_fetch),
        .stall_cause(stall_cause), .credit_err(credit_err), .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cr(int k);
        return 32'(ch_credit[k*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [31:0] pf(int k);
        return 32'(perf_stall_cnt[k*16 +: 16]);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_rec == 0 && !flush && disp_ch < NUM_CH && m_cr[int'(disp_ch)] > 0 && m_rob > 0 && (!disp_is_mem || m_lsq > 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_cr[k] = DEPTH[k];
        for (int k = 0; k < NUM_CH + 2; k++) m_perf[k] = 0;
        m_rob = ROB_SIZE;
        m_lsq = LSQ_SIZE;
        m_rec = 0;
        m_dec = 0;
        m_fetch = 0;
        m_err = 0;
        m_cause = '0;
    endtask

    task automatic model_step();
        bit rdy, fire, live;
        int d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = m_ready();
        fire = disp_valid && rdy;
        live = m_rec == 0 && !flush;
        if (disp_valid && !rdy) begin
            if (disp_ch < NUM_CH && m_cr[int'(disp_ch)] == 0 && m_perf[int'(disp_ch)] < 65535) m_perf[int'(disp_ch)]++;
            if (m_rob == 0 && m_perf[NUM_CH] < 65535) m_perf[NUM_CH]++;
            if (disp_is_mem && m_lsq == 0 && m_perf[NUM_CH+1] < 65535) m_perf[NUM_CH+1]++;
        end
        if (flush) begin
            for (int k = 0; k < NUM_CH; k++) m_cr[k] = DEPTH[k];
            m_rob = ROB_SIZE;
            m_lsq = LSQ_SIZE;
            m_rec = FLUSH_CYCLES;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                d = int'(live && rs_release[k]) - int'(fire && int'(disp_ch) == k);
                if (m_cr[k] + d > DEPTH[k]) m_err = 1; else m_cr[k] += d;
            end
            d = int'(live && rob_commit) - int'(fire);
            if (m_rob + d > ROB_SIZE) m_err = 1; else m_rob += d;
            d = int'(live && lsq_release) - int'(fire && disp_is_mem);
            if (m_lsq + d > LSQ_SIZE) m_err = 1; else m_lsq += d;
            if (m_rec > 0) m_rec--;
        end
        m_fetch = m_dec;
        for (int k = 0; k < NUM_CH; k++) m_cause[k] = m_cr[k] <= WM;
        m_cause[NUM_CH] = m_rob <= WM;
        m_cause[NUM_CH+1] = m_lsq <= WM;
        m_dec = |m_cause || m_rec > 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(bit v, int ch, bit mem, logic [NUM_CH-1:0] rel, bit commit, bit lrel, bit fl);
        disp_valid = v;
        disp_ch = 3'(ch);
        disp_is_mem = mem;
        rs_release = rel;
        rob_commit = commit;
        lsq_release = lrel;
        flush = fl;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("disp_ready", disp_ready, m_ready());
            chk("stall_dispatch", stall_dispatch, disp_valid && !m_ready());
            for (int k = 0; k < NUM_CH; k++) chk($sformatf("credit%0d", k), cr(k), m_cr[k]);
            chk("stall_decode", stall_decode, m_dec);
            chk("stall_fetch", stall_fetch, m_fetch);
            chk("stall_cause", 32'(stall_cause), 32'(m_cause));
            chk("credit_err", credit_err, m_err);
            for (int k = 0; k < NUM_CH + 2; k++) begin
`ifdef STALL_CREDIT_PERF_EN
                chk($sformatf("perf%0d", k), pf(k), m_perf[k]);
`else
                chk($sformatf("perf%0d", k), pf(k), 0);
`endif
            end
        end
    end

    initial begin
        drive(0, 0, 0, '0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        #2;
        chk("rst_credit2", cr(2), 4);
        chk("rst_credit0", cr(0), 8);
        chk("rst_ready", disp_ready, 1);
        chk("rst_decode", stall_decode, 0);
        chk("rst_err", credit_err, 0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 2, 0, '0, 0, 0, 0);
            #2;
            chk("mul_ready", disp_ready, i < 4);
            chk("mul_credit2", cr(2), 4 - i);
            chk("mul_cause2", stall_cause[2], i >= 3);
            step();
        end

        drive(1, 2, 0, 5'b00100, 0, 0, 0);
        #2;
        chk("rel_ready0", disp_ready, 0);
        step();
        drive(1, 2, 0, '0, 0, 0, 0);
        #2;
        chk("rel_credit2", cr(2), 1);
        chk("rel_ready1", disp_ready, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, '0, 1, 0, 0);
            step();
        end
        drive(1, 0, 0, 5'b00001, 1, 0, 0);
        #2;
        chk("net_pre_credit0", cr(0), 3);
        step();
        drive(0, 0, 0, '0, 0, 0, 0);
        #2;
        chk("net_credit0", cr(0), 3);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 5'b00001, 1, 0, 0);
            step();
        end
        drive(0, 0, 0, '0, 0, 0, 0);
        #2;
        chk("refill_credit0", cr(0), 8);

        for (int i = 0; i < 16; i++) begin
            drive(1, (i % 2 == 1) ? 4 : 0, 0, '0, 0, 0, 0);
            #2;
            chk("rob_fill_ready", disp_ready, 1);
            step();
        end
        drive(1, 1, 0, '0, 0, 0, 0);
        #2;
        chk("rob_empty_ready", disp_ready, 0);
        chk("rob_empty_cause", stall_cause[NUM_CH], 1);
        chk("rob_empty_stall", stall_dispatch, 1);
        step();
        drive(0, 1, 0, '0, 1, 0, 0);
        step();
        drive(1, 1, 0, '0, 0, 0, 0);
        #2;
        chk("rob_one_ready", disp_ready, 1);
        chk("rob_one_cause", stall_cause[NUM_CH], 1);

        drive(1, 1, 0, '0, 0, 0, 1);
        #2;
        chk("flush_ready", disp_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, '0, 0, 0, 0);
            #2;
            if (i == 0) begin
                chk("flush_credit0", cr(0), 8);
                chk("flush_credit2", cr(2), 4);
                chk("flush_credit4", cr(4), 8);
            end
            chk("rec_ready", disp_ready, i >= 3);
            chk("rec_decode", stall_decode, i < 3);
            chk("rec_fetch", stall_fetch, i < 4);
            step();
        end

        drive(0, 0, 0, 5'b00001, 0, 0, 0);
        step();
        drive(0, 0, 0, '0, 0, 0, 0);
        #2;
        chk("ovf_credit0", cr(0), 8);
        chk("ovf_err", credit_err, 1);
        step();
        step();
        step();
        chk("err_sticky", credit_err, 1);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("err_reset", credit_err, 0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 1, '0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 3, 0, '0, 0, 0, 0);
            #2;
            chk("div_ready", disp_ready, 0);
            step();
        end
        drive(0, 0, 0, '0, 0, 0, 0);
        #2;
        chk("div_credit3", cr(3), 0);
`ifdef STALL_CREDIT_PERF_EN
        chk("perf_div", pf(3), 10);
        chk("perf_alu", pf(0), 0);
        chk("perf_rob", pf(NUM_CH), 0);
`else
        chk("perf_div", pf(3), 0);
`endif

        drive(1, 5, 0, '0, 0, 0, 0);
        #2;
        chk("oor_ready", disp_ready, 0);
        chk("oor_stall", stall_dispatch, 1);
        step();
        drive(1, 7, 1, '0, 0, 0, 0);
        step();
        drive(0, 0, 0, '0, 0, 0, 0);
        #2;
        chk("oor_credit3", cr(3), 0);
        chk("oor_credit0", cr(0), 8);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
